// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock display path.
// Holds the BCD digit type, segment constants and the digit-index encoding.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 6;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        DIG_S_L = 3'd0,
        DIG_S_M = 3'd1,
        DIG_M_L = 3'd2,
        DIG_M_M = 3'd3,
        DIG_H_L = 3'd4,
        DIG_H_M = 3'd5
    } dig_idx_e;

    // Digits carrying the H.M.S separator dot
    function automatic logic is_sep_digit(input dig_idx_e d);
        return (d == DIG_M_L) || (d == DIG_H_L);
    endfunction

endpackage

// File: rtl/disp_mux_if.sv
// Bus between the time counters / board pins and the display multiplexer.
// dmux_blink_sel exists only when DMUX_BLINK_EN is defined.
interface disp_mux_if;

    logic       dmux_enable;
    logic [3:0] dmux_h_Lsd;
    logic [1:0] dmux_h_Msd;
    logic [3:0] dmux_m_Lsd;
    logic [2:0] dmux_m_Msd;
    logic [3:0] dmux_s_Lsd;
    logic [2:0] dmux_s_Msd;
`ifdef DMUX_BLINK_EN
    logic [1:0] dmux_blink_sel;
`endif
    logic [5:0] dmux_anode;
    logic [6:0] dmux_seg;
    logic       dmux_dp;

    modport master (
        output dmux_enable, dmux_h_Lsd, dmux_h_Msd, dmux_m_Lsd, dmux_m_Msd,
               dmux_s_Lsd, dmux_s_Msd,
`ifdef DMUX_BLINK_EN
        output dmux_blink_sel,
`endif
        input  dmux_anode, dmux_seg, dmux_dp
    );

    modport slave (
        input  dmux_enable, dmux_h_Lsd, dmux_h_Msd, dmux_m_Lsd, dmux_m_Msd,
               dmux_s_Lsd, dmux_s_Msd,
`ifdef DMUX_BLINK_EN
        input  dmux_blink_sel,
`endif
        output dmux_anode, dmux_seg, dmux_dp
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder, {g,f,e,d,c,b,a}.
// Non-decimal codes 10-15 render as a dash.
module bcd_to_seg
    import clock_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_mux.sv
// Six-digit common-anode display scanner with per-frame snapshot and registered pin outputs.
// Define DMUX_BLINK_EN to add field blinking driven by dmux_blink_sel.
module disp_mux
    import clock_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic      dmux_clock,
    input  logic      dmux_reset,
    disp_mux_if.slave bus
);

    localparam int DIV   = CLK_HZ / (SCAN_HZ * 6);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("disp_mux: CLK_HZ/(SCAN_HZ*6) must be at least 2");
        end
        if (BLINK_HZ < 1) begin : g_blink_check
            $error("disp_mux: BLINK_HZ must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0]            presc_q, presc_d;
    dig_idx_e                    idx_q, idx_d;
    bcd_t [NUM_DIGITS-1:0]       snap_q, snap_d;
    logic                        primed_q, primed_d;
    logic [5:0]                  anode_q, anode_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        dp_q, dp_d;

    logic                        en;
    logic                        tick;
    logic                        take;
    logic                        blink_blank;
    bcd_t [NUM_DIGITS-1:0]       in_digits;
    bcd_t                        cur_digit;
    logic [6:0]                  dec_seg;

    assign en = bus.dmux_enable;

    // Msd fields zero-extended so every snapshot slot is a full BCD digit
    assign in_digits = {{2'b00, bus.dmux_h_Msd}, bus.dmux_h_Lsd,
                        {1'b0,  bus.dmux_m_Msd}, bus.dmux_m_Lsd,
                        {1'b0,  bus.dmux_s_Msd}, bus.dmux_s_Lsd};

    always_comb begin
        tick     = en && (presc_q == CNT_LAST);
        presc_d  = presc_q;
        if (en) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
        end

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == DIG_H_M) ? DIG_S_L : dig_idx_e'(idx_q + 3'd1);
        end

        // A fresh frame starts at the 5->0 wrap, or at the first enabled cycle after reset
        take     = en && (!primed_q || (tick && (idx_q == DIG_H_M)));
        primed_d = primed_q | take;
        snap_d   = take ? in_digits : snap_q;
        // The digit shown this edge already uses the just-captured frame
        cur_digit = snap_d[idx_d];
    end

    bcd_to_seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

`ifdef DMUX_BLINK_EN
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [1:0]         sel_q, sel_d;

    always_comb begin
        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
        phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
        sel_d       = take ? bus.dmux_blink_sel : sel_q;
        // Field code of a digit pair is idx/2 + 1 (01 sec, 10 min, 11 hour)
        blink_blank = phase_q && (sel_d != 2'b00) && (sel_d == (idx_d[2:1] + 2'd1));
    end

    always_ff @(posedge dmux_clock or negedge dmux_reset) begin
        if (!dmux_reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sel_q       <= 2'b00;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
        end
    end
`else
    assign blink_blank = 1'b0;
`endif

    always_comb begin
        anode_d = 6'b111111;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (en) begin
            anode_d[idx_d] = 1'b0;
            if (!blink_blank) begin
                seg_d = dec_seg;
                dp_d  = !is_sep_digit(idx_d);
            end
        end
    end

    always_ff @(posedge dmux_clock or negedge dmux_reset) begin
        if (!dmux_reset) begin
            presc_q  <= '0;
            idx_q    <= DIG_S_L;
            snap_q   <= '0;
            primed_q <= 1'b0;
            anode_q  <= 6'b111111;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            primed_q <= primed_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.dmux_anode = anode_q;
    assign bus.dmux_seg   = seg_q;
    assign bus.dmux_dp    = dp_q;

endmodule

// File: tb/tb_disp_mux.sv
// Directed bench for disp_mux with DIV=10 (CLK_HZ=600, SCAN_HZ=10).
// Outputs are sampled on the falling clock edge.
module tb_disp_mux;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    disp_mux_if bus ();

    disp_mux #(
        .CLK_HZ   (600),
        .SCAN_HZ  (10),
        .BLINK_HZ (30)
    ) dut (
        .dmux_clock (clk),
        .dmux_reset (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // 12:34:56, then 12:34:57 with hour units 9 from frame 2, then seconds units 0xC in frame 3
    logic [6:0] walk_seg [13] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79,
                                  7'h78, 7'h12, 7'h19, 7'h30, 7'h10, 7'h79,
                                  7'h3F};
    // 08:15:42 after the mid-dwell reset
    logic [6:0] rst_seg [6] = '{7'h24, 7'h19, 7'h12, 7'h79, 7'h00, 7'h40};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("check %s: got=%0h ok", tag, got);
        end
    endtask

    task automatic check_digit(input string tag, input int d, input logic [6:0] seg_exp);
        logic [5:0] an_exp;
        logic       dp_exp;
        an_exp    = 6'b111111;
        an_exp[d] = 1'b0;
        dp_exp    = (d == 2 || d == 4) ? 1'b0 : 1'b1;
        check_eq({tag, "_anode"}, 32'(bus.dmux_anode), 32'(an_exp));
        check_eq({tag, "_seg"},   32'(bus.dmux_seg),   32'(seg_exp));
        check_eq({tag, "_dp"},    32'(bus.dmux_dp),    32'(dp_exp));
    endtask

    task automatic check_blank(input string tag);
        check_eq({tag, "_anode"}, 32'(bus.dmux_anode), 32'h3F);
        check_eq({tag, "_seg"},   32'(bus.dmux_seg),   32'h7F);
        check_eq({tag, "_dp"},    32'(bus.dmux_dp),    32'h1);
    endtask

    task automatic set_time(input int hm, input int hl, input int mm, input int ml,
                            input int sm, input int sl);
        bus.dmux_h_Msd = 2'(hm);
        bus.dmux_h_Lsd = 4'(hl);
        bus.dmux_m_Msd = 3'(mm);
        bus.dmux_m_Lsd = 4'(ml);
        bus.dmux_s_Msd = 3'(sm);
        bus.dmux_s_Lsd = 4'(sl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.dmux_enable = 1'b1;
`ifdef DMUX_BLINK_EN
        bus.dmux_blink_sel = 2'b00;
`endif
        set_time(1, 2, 3, 4, 5, 6);

        repeat (2) @(negedge clk);
        check_blank("reset");

        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            repeat ((k == 0) ? 1 : ((k == 1) ? 9 : 10)) @(negedge clk);
            check_digit($sformatf("walk%0d", k), k % 6, walk_seg[k]);
            if (k == 3) begin
                bus.dmux_s_Lsd = 4'd7;
                bus.dmux_h_Lsd = 4'd9;
            end
            if (k == 9) begin
                bus.dmux_s_Lsd = 4'hC;
            end
        end

        // Index 2 with prescaler at 4
        repeat (24) @(negedge clk);
        check_digit("pre_hold", 2, 7'h19);
        bus.dmux_enable = 1'b0;
        @(negedge clk);
        check_blank("hold_first");
        repeat (24) @(negedge clk);
        check_blank("hold_last");
        bus.dmux_enable = 1'b1;
        @(negedge clk);
        check_digit("resume", 2, 7'h19);
        repeat (4) @(negedge clk);
        check_digit("resume_dwell", 2, 7'h19);
        @(negedge clk);
        check_digit("resume_tick", 3, 7'h30);

        // Asynchronous reset while the clock is low
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_blank("async_rst");
        set_time(0, 8, 1, 5, 4, 2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            repeat ((k == 0) ? 1 : ((k == 1) ? 9 : 10)) @(negedge clk);
            check_digit($sformatf("post_rst%0d", k), k, rst_seg[k]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
